pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush controller. Drives the en/flush pair of the four pipeline registers
//  (F/D, D/E, E/M, M/W) and the PC-update enable. Collects busy/hazard/redirect events from all stages.
//  Sequences redirects that collide with memory stalls or with in-flight instruction fetches.
//  Sits beside the datapath in the core top; every pipeline register's flush/en comes from here.
// PARAMETERS
//  STALL_CNT_W  16  width of saturating stall-cycle performance counter
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous, active-high
//  i_busy            in   1   fetch waiting on imem response
//  ex_busy           in   1   multi-cycle mul/div occupying EX
//  load_use          in   1   load-use hazard detected in ID
//  d_busy            in   1   MEM waiting on dmem response
//  br_redirect       in   1   EX resolved mispredict, 1-cycle pulse
//  trap              in   1   exception/interrupt at commit, 1-cycle pulse
//  en                out  4   pipereg enables, bit0=F/D 1=D/E 2=E/M 3=M/W
//  flush             out  4   pipereg flushes, same bit order (flush beats en in pipereg)
//  pc_en             out  1   PC register update (next-seq or redirect target)
//  redirect_pending  out  1   redirect latched, PC unit must hold its target
//  stall_cycles      out  STALL_CNT_W  saturating count of cycles with pc_en=0
// BEHAVIOUR
//  - Outputs en/flush/pc_en are combinational from inputs+state; state/counter are registered.
//  - Reset cycle: en=0000, flush=1111, pc_en=0, redirect_pending=0. State<=RUN, latched kind<=NONE.
//    stall_cycles<=0. Reset mid-HOLD/DRAIN abandons the latched redirect.
//  - Stall table (RUN, no redirect), priority top-down, en/flush as {MW,EM,DE,FD}:
//      d_busy  : en=0000 flush=0000 pc_en=0
//      ex_busy : en=1000 flush=0100 pc_en=0
//      load_use: en=1100 flush=0010 pc_en=0
//      i_busy  : en=1110 flush=0001 pc_en=0
//      none    : en=1111 flush=0000 pc_en=1
//  - Redirect patterns: BR = en=1100 flush=0011 pc_en=1; TRAP = en=0000 flush=1111 pc_en=1.
//    Both pulses in one cycle -> TRAP. Redirect overrides ex_busy/load_use/i_busy rows, never d_busy.
//  - FSM states RUN, HOLD, DRAIN:
//    RUN : redirect & d_busy -> latch kind, HOLD. Otherwise redirect applies this cycle.
//          Then -> DRAIN if i_busy, else stays RUN.
//    HOLD: en=0000 flush=0000 pc_en=0 redirect_pending=1. Trap pulse in HOLD upgrades kind to TRAP.
//          BR in HOLD is ignored. On d_busy==0: apply latched pattern, clear kind.
//          Then -> DRAIN if i_busy, else RUN.
//    DRAIN: stale fetch in flight. FD flush forced 1, pc_en=0. Other bits follow the stall table.
//           Trap -> TRAP pattern but pc_en=1, stays DRAIN. i_busy==0 -> FD still flushed this cycle, ->RUN.
//  - stall_cycles increments when pc_en==0 (reset excluded), saturates at all-ones, never wraps.
// STRUCTURE
//  - Package common: typedef enum ctrl_state_t {RUN,HOLD,DRAIN}; redir_kind_t {NONE,BR,TRAP}.
//    Also localparams STG_FD=0, STG_DE=1, STG_EM=2, STG_MW=3.
//  - One sub-module: sat_counter #(W) (clk, reset, inc, count) for stall_cycles.
//  - Remainder: state/kind registers plus one always_comb priority block.
// TESTING
//  1 reset high 2 cycles -> en=0000 flush=1111 pc_en=0; after release, idle -> en=1111 flush=0000 pc_en=1.
//  2 load_use=1 for 1 cycle -> en=1100 flush=0010 pc_en=0; next cycle en=1111.
//  3 d_busy=1 for 3 cycles + br_redirect at cycle 1 -> HOLD, redirect_pending=1 cycles 1-3.
//    Cycle 4: en=1100 flush=0011 pc_en=1; stall_cycles=+3.
//  4 br_redirect with i_busy=1 for 2 more cycles -> redirect cycle flush=0011 pc_en=1.
//    Then DRAIN: FD flushed, pc_en=0 for 2 cycles; RUN after i_busy falls.
//  5 br_redirect & trap same cycle -> flush=1111 en=0000 pc_en=1.
//    Trap during HOLD latched as BR -> release applies flush=1111.
//  6 force pc_en=0 for 2^16+5 cycles -> stall_cycles stays 16'hFFFF; reset mid-HOLD -> RUN, pending=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, stage indices and redirect patterns for the pipeline controller
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, HOLD, DRAIN} ctrl_state_t;
   typedef enum logic [1:0] {NONE, BR, TRAP} redir_kind_t;
   localparam int STG_FD = 0;
   localparam int STG_DE = 1;
   localparam int STG_EM = 2;
   localparam int STG_MW = 3;
   // {en[3:0], flush[3:0], pc_en}; a branch keeps EM/MW moving, a trap squashes everything
   function automatic logic [8:0] redir_pat(input redir_kind_t k);
      return (k == TRAP) ? 9'b0000_1111_1 : 9'b1100_0011_1;
   endfunction
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: saturating up-counter, holds at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   // count up on inc until every bit is set
   always_ff @(posedge clk)
      if (reset) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the four pipeline registers and the PC
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_busy,
   input  logic                   ex_busy,
   input  logic                   load_use,
   input  logic                   d_busy,
   input  logic                   br_redirect,
   input  logic                   trap,
   output logic [3:0]             en,
   output logic [3:0]             flush,
   output logic                   pc_en,
   output logic                   redirect_pending,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   ctrl_state_t state_q, state_d;
   redir_kind_t kind_q, kind_d, req_kind, rel_kind;
   assign req_kind = trap ? TRAP : (br_redirect ? BR : NONE);
   assign rel_kind = trap ? TRAP : kind_q;
   // priority decode: reset, then held/draining redirects, then fresh redirect over the stall table
   always_comb begin
      state_d = state_q;
      kind_d = kind_q;
      redirect_pending = 1'b0;
      {en, flush, pc_en} = d_busy   ? 9'b0000_0000_0 :
                           ex_busy  ? 9'b1000_0100_0 :
                           load_use ? 9'b1100_0010_0 :
                           i_busy   ? 9'b1110_0001_0 : 9'b1111_0000_1;
      if (reset) begin
         {en, flush, pc_en} = 9'b0000_1111_0;
      end else if (state_q == HOLD) begin
         if (d_busy) begin
            redirect_pending = 1'b1;
            kind_d = rel_kind;
         end else begin
            {en, flush, pc_en} = redir_pat(rel_kind);
            kind_d = NONE;
            state_d = i_busy ? DRAIN : RUN;
         end
      end else if (state_q == DRAIN) begin
         flush[STG_FD] = 1'b1;
         pc_en = 1'b0;
         if (trap && d_busy) begin
            redirect_pending = 1'b1;
            kind_d = TRAP;
            state_d = HOLD;
         end else if (trap) begin
            {en, flush, pc_en} = redir_pat(TRAP);
         end else if (!i_busy) begin
            state_d = RUN;
         end
      end else if (req_kind != NONE) begin
         if (d_busy) begin
            redirect_pending = 1'b1;
            kind_d = req_kind;
            state_d = HOLD;
         end else begin
            {en, flush, pc_en} = redir_pat(req_kind);
            state_d = i_busy ? DRAIN : RUN;
         end
      end
   end
   // state and latched redirect kind; reset abandons any latched redirect
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= RUN;
         kind_q <= NONE;
      end else begin
         state_q <= state_d;
         kind_q <= kind_d;
      end
   sat_counter #(.W(STALL_CNT_W)) u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (~pc_en),
      .count (stall_cycles)
   );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic i_busy = 1'b0, ex_busy = 1'b0, load_use = 1'b0, d_busy = 1'b0, br_redirect = 1'b0, trap = 1'b0;
   logic [3:0] en, flush;
   logic pc_en, redirect_pending;
   logic [15:0] stall_cycles;
   int checks = 0, errors = 0;
   bit m_hold = 0, m_drain = 0;
   int m_kind = 0;
   int m_cnt = 0;

   pipe_ctrl #(.STALL_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .i_busy(i_busy), .ex_busy(ex_busy), .load_use(load_use),
      .d_busy(d_busy), .br_redirect(br_redirect), .trap(trap), .en(en), .flush(flush),
      .pc_en(pc_en), .redirect_pending(redirect_pending), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // expected {en, flush, pc_en, redirect_pending} for the current inputs and model mode
   function automatic logic [9:0] model_out();
      logic [8:0] v;
      logic q;
      logic [8:0] br_p, tr_p;
      br_p = 9'b1100_0011_1;
      tr_p = 9'b0000_1111_1;
      q = 1'b0;
      if (reset) return 10'b0000_1111_0_0;
      if (d_busy) v = 9'b0000_0000_0;
      else if (ex_busy) v = 9'b1000_0100_0;
      else if (load_use) v = 9'b1100_0010_0;
      else if (i_busy) v = 9'b1110_0001_0;
      else v = 9'b1111_0000_1;
      if (m_hold) begin
         if (d_busy) q = 1'b1;
         else v = (trap || m_kind == 2) ? tr_p : br_p;
      end else if (m_drain) begin
         v[1] = 1'b1;
         v[0] = 1'b0;
         if (trap && d_busy) q = 1'b1;
         else if (trap) v = tr_p;
      end else if (trap || br_redirect) begin
         if (d_busy) q = 1'b1;
         else v = trap ? tr_p : br_p;
      end
      return {v, q};
   endfunction

   // model mode update and stall counter, evaluated from the inputs present at each edge
   always @(posedge clk) begin
      logic [9:0] o;
      o = model_out();
      if (reset) begin
         m_hold = 0; m_drain = 0; m_kind = 0; m_cnt = 0;
      end else begin
         if (!o[1] && m_cnt < 65535) m_cnt = m_cnt + 1;
         if (m_hold) begin
            if (d_busy) begin
               if (trap) m_kind = 2;
            end else begin
               m_hold = 0; m_kind = 0; m_drain = i_busy;
            end
         end else if (m_drain) begin
            if (trap && d_busy) begin
               m_hold = 1; m_kind = 2; m_drain = 0;
            end else if (!trap && !i_busy) m_drain = 0;
         end else if (trap || br_redirect) begin
            if (d_busy) begin
               m_hold = 1; m_kind = trap ? 2 : 1;
            end else m_drain = i_busy;
         end
      end
   end

   // apply {d_busy, ex_busy, load_use, i_busy, br_redirect, trap} for one cycle, stop mid-cycle
   task automatic cyc(input logic [5:0] v);
      @(posedge clk);
      #1;
      {d_busy, ex_busy, load_use, i_busy, br_redirect, trap} = v;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_1111_0_0) begin
         errors++; $display("FAIL reset_c1 obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_1111_0_0);
      end
      @(posedge clk); #1; @(negedge clk);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_1111_0_0) begin
         errors++; $display("FAIL reset_c2 obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_1111_0_0);
      end
      @(posedge clk); #1; reset = 1'b0; @(negedge clk);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1111_0000_1_0) begin
         errors++; $display("FAIL idle_after_reset obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1111_0000_1_0);
      end
      checks++;
      if (stall_cycles !== 16'd0) begin
         errors++; $display("FAIL stall_reset obs=%0d exp=0", stall_cycles);
      end
   endtask

   task automatic test_load_use();
      cyc(6'b001000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1100_0010_0_0) begin
         errors++; $display("FAIL load_use obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1100_0010_0_0);
      end
      cyc(6'b000000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1111_0000_1_0) begin
         errors++; $display("FAIL load_use_after obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1111_0000_1_0);
      end
   endtask

   task automatic test_hold_release();
      int base;
      base = m_cnt;
      for (int c = 1; c <= 3; c++) begin
         cyc(c == 1 ? 6'b100010 : 6'b100000);
         checks++;
         if ({en, flush, pc_en, redirect_pending} !== 10'b0000_0000_0_1) begin
            errors++; $display("FAIL hold_c%0d obs=%b exp=%b", c, {en, flush, pc_en, redirect_pending}, 10'b0000_0000_0_1);
         end
      end
      cyc(6'b000000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1100_0011_1_0) begin
         errors++; $display("FAIL hold_release obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1100_0011_1_0);
      end
      checks++;
      if (stall_cycles !== 16'(base + 3)) begin
         errors++; $display("FAIL hold_stall_count obs=%0d exp=%0d", stall_cycles, base + 3);
      end
   endtask

   task automatic test_drain();
      cyc(6'b000110);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1100_0011_1_0) begin
         errors++; $display("FAIL drain_redirect obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1100_0011_1_0);
      end
      for (int c = 0; c < 2; c++) begin
         cyc(6'b000100);
         checks++;
         if ({en, flush, pc_en, redirect_pending} !== 10'b1110_0001_0_0) begin
            errors++; $display("FAIL drain_busy%0d obs=%b exp=%b", c, {en, flush, pc_en, redirect_pending}, 10'b1110_0001_0_0);
         end
      end
      cyc(6'b000000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1111_0001_0_0) begin
         errors++; $display("FAIL drain_last obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1111_0001_0_0);
      end
      cyc(6'b000000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b1111_0000_1_0) begin
         errors++; $display("FAIL drain_run obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b1111_0000_1_0);
      end
   endtask

   task automatic test_trap();
      cyc(6'b000011);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_1111_1_0) begin
         errors++; $display("FAIL trap_and_br obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_1111_1_0);
      end
      cyc(6'b100010);
      cyc(6'b100001);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_0000_0_1) begin
         errors++; $display("FAIL trap_in_hold obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_0000_0_1);
      end
      cyc(6'b000000);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_1111_1_0) begin
         errors++; $display("FAIL trap_upgrade_release obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_1111_1_0);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         reset = ($urandom_range(99) == 0);
         d_busy = ($urandom_range(99) < 25);
         ex_busy = ($urandom_range(99) < 15);
         load_use = ($urandom_range(99) < 15);
         i_busy = ($urandom_range(99) < 35);
         br_redirect = ($urandom_range(99) < 12);
         trap = ($urandom_range(99) < 6);
         @(negedge clk);
         checks++;
         if ({en, flush, pc_en, redirect_pending} !== model_out()) begin
            errors++; $display("FAIL rand_outputs cyc=%0d obs=%b exp=%b", c, {en, flush, pc_en, redirect_pending}, model_out());
         end
         checks++;
         if (stall_cycles !== 16'(m_cnt)) begin
            errors++; $display("FAIL rand_stall cyc=%0d obs=%0d exp=%0d", c, stall_cycles, m_cnt);
         end
      end
      reset = 1'b0;
      cyc(6'b000000);
   endtask

   task automatic test_saturate();
      @(posedge clk); #1;
      {d_busy, ex_busy, load_use, i_busy, br_redirect, trap} = 6'b100000;
      repeat (65536 + 5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall_cycles !== 16'hFFFF) begin
         errors++; $display("FAIL stall_saturate obs=%h exp=ffff", stall_cycles);
      end
      cyc(6'b100010);
      checks++;
      if ({redirect_pending, stall_cycles} !== {1'b1, 16'hFFFF}) begin
         errors++; $display("FAIL sat_hold obs=%b/%h exp=1/ffff", redirect_pending, stall_cycles);
      end
      @(posedge clk); #1; reset = 1'b1; @(negedge clk);
      checks++;
      if ({en, flush, pc_en, redirect_pending} !== 10'b0000_1111_0_0) begin
         errors++; $display("FAIL reset_mid_hold obs=%b exp=%b", {en, flush, pc_en, redirect_pending}, 10'b0000_1111_0_0);
      end
      @(posedge clk); #1; reset = 1'b0; d_busy = 1'b0; br_redirect = 1'b0; @(negedge clk);
      checks++;
      if ({en, flush, pc_en, redirect_pending, stall_cycles} !== {10'b1111_0000_1_0, 16'd0}) begin
         errors++; $display("FAIL after_reset_hold obs=%b/%0d exp=%b/0", {en, flush, pc_en, redirect_pending}, stall_cycles, 10'b1111_0000_1_0);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_hold_release();
      test_drain();
      test_trap();
      test_random();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
